// File: rtl/instruction_fetch_if.sv
// Bus between the IF stage (master) and its instruction memory / decode stage (slave side).
// Carries the read handshake, redirect/stall controls and the decoded IF/ID fields.
interface instruction_fetch_if;
  logic        stall;
  logic        branchTaken;
  logic [15:0] branchTarget;
  logic        memReady;
  logic [15:0] memData;
  logic        memRead;
  logic [15:0] memAddress;
  logic        valid;
  logic [15:0] instruction;
  logic [15:0] pcOut;
  logic [3:0]  opcode;
  logic [2:0]  rs;
  logic [2:0]  rt;
  logic [2:0]  rd;
  logic [2:0]  funct;
  logic [5:0]  signalToExtend;
  logic        halted;

  modport master (
    input  stall, branchTaken, branchTarget, memReady, memData,
    output memRead, memAddress, valid, instruction, pcOut,
           opcode, rs, rt, rd, funct, signalToExtend, halted
  );

  modport slave (
    output stall, branchTaken, branchTarget, memReady, memData,
    input  memRead, memAddress, valid, instruction, pcOut,
           opcode, rs, rt, rd, funct, signalToExtend, halted
  );
endinterface

// File: rtl/instruction_fetch.sv
// IF stage: PC, ready-based instruction read with bounded-wait retry, IF/ID register.
// Optional HALT_DETECT_EN: opcode 4'hF parks the fetcher in HALT until reset.
module instruction_fetch #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] PC_STEP    = 16'h0001,
  parameter int unsigned WAIT_LIMIT = 8
) (
  input  logic                clock,
  input  logic                reset,
  instruction_fetch_if.master fetchBus
);

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RETRY = 2'd2
`ifdef HALT_DETECT_EN
    , HALT = 2'd3
`endif
  } fetchState_t;

  fetchState_t stateR;
  fetchState_t stateNextS;
  logic [15:0] pcR;
  logic [15:0] pcNextS;
  logic        validR;
  logic        validNextS;
  logic [15:0] instructionR;
  logic [15:0] instructionNextS;
  logic [15:0] pcOutR;
  logic [15:0] pcOutNextS;
  logic [7:0]  waitCountR;
  logic [7:0]  waitCountNextS;
  logic        acceptS;
  logic        memReadS;
  logic        loadS;
  logic        haltActiveS;

`ifdef HALT_DETECT_EN
  logic        haltedR;
  logic        haltedNextS;
  assign haltActiveS = (stateR == HALT);
`else
  assign haltActiveS = 1'b0;
`endif

  // Read request: only in FETCH, only when the output register can take a word, never on redirect.
  always_comb begin
    acceptS  = !validR || !fetchBus.stall;
    memReadS = (stateR == FETCH) && acceptS && !fetchBus.branchTaken;
    loadS    = memReadS && fetchBus.memReady;
  end

  // Next-state and next-datapath values; redirect outranks every other event except reset.
  always_comb begin
    stateNextS       = stateR;
    pcNextS          = pcR;
    validNextS       = validR;
    instructionNextS = instructionR;
    pcOutNextS       = pcOutR;
    waitCountNextS   = waitCountR;
`ifdef HALT_DETECT_EN
    haltedNextS      = haltedR;
`endif
    if (fetchBus.branchTaken && !haltActiveS) begin
      stateNextS     = FETCH;
      pcNextS        = fetchBus.branchTarget;
      validNextS     = 1'b0;
      waitCountNextS = 8'd0;
    end else begin
      case (stateR)
        IDLE: begin
          stateNextS = FETCH;
        end
        FETCH: begin
          if (loadS) begin
            instructionNextS = fetchBus.memData;
            pcOutNextS       = pcR;
            pcNextS          = pcR + PC_STEP;
            waitCountNextS   = 8'd0;
`ifdef HALT_DETECT_EN
            if (fetchBus.memData[15:12] == 4'hF) begin
              stateNextS  = HALT;
              haltedNextS = 1'b1;
            end else begin
              stateNextS  = FETCH;
            end
`endif
          end else if (memReadS) begin
            // The cycle that completes WAIT_LIMIT unanswered requests drops the request for one cycle.
            if (waitCountR == WAIT_LAST) begin
              stateNextS     = RETRY;
              waitCountNextS = 8'd0;
            end else begin
              waitCountNextS = waitCountR + 8'd1;
            end
          end else begin
            stateNextS = FETCH;
          end
        end
        RETRY: begin
          stateNextS = FETCH;
        end
`ifdef HALT_DETECT_EN
        HALT: begin
          stateNextS = HALT;
        end
`endif
        default: begin
          stateNextS = IDLE;
        end
      endcase

      if (loadS) begin
        validNextS = 1'b1;
      end else if (validR && !fetchBus.stall) begin
        validNextS = 1'b0;
      end else begin
        validNextS = validR;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      stateR <= IDLE;
    end else begin
      stateR <= stateNextS;
    end
  end

  // PC, IF/ID register and wait counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      pcR          <= RESET_PC;
      validR       <= 1'b0;
      instructionR <= 16'h0000;
      pcOutR       <= 16'h0000;
      waitCountR   <= 8'd0;
    end else begin
      pcR          <= pcNextS;
      validR       <= validNextS;
      instructionR <= instructionNextS;
      pcOutR       <= pcOutNextS;
      waitCountR   <= waitCountNextS;
    end
  end

`ifdef HALT_DETECT_EN
  // Sticky halt flag, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      haltedR <= 1'b0;
    end else begin
      haltedR <= haltedNextS;
    end
  end
  assign fetchBus.halted = haltedR;
`else
  assign fetchBus.halted = 1'b0;
`endif

  assign fetchBus.memRead        = memReadS;
  assign fetchBus.memAddress     = pcR;
  assign fetchBus.valid          = validR;
  assign fetchBus.instruction    = instructionR;
  assign fetchBus.pcOut          = pcOutR;
  assign fetchBus.opcode         = instructionR[15:12];
  assign fetchBus.rs             = instructionR[11:9];
  assign fetchBus.rt             = instructionR[8:6];
  assign fetchBus.rd             = instructionR[5:3];
  assign fetchBus.funct          = instructionR[2:0];
  assign fetchBus.signalToExtend = instructionR[5:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed steps plus random stall/ready/branch
// traffic checked every cycle against a transaction-level model of the fetch stream.
module tb_instruction_fetch;
  localparam int WAIT_LIMIT = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   assertCount = 0;
  int   failCount = 0;

  instruction_fetch_if bus();

  instruction_fetch #(
    .RESET_PC  (16'h0000),
    .PC_STEP   (16'h0001),
    .WAIT_LIMIT(WAIT_LIMIT)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .fetchBus(bus)
  );

  always #5 clock = ~clock;

  // Instruction memory contents: a per-address pattern plus one overridable location.
  int          memMode = 0;
  logic        ovEn = 1'b0;
  logic [15:0] ovAddr = 16'h0000;
  logic [15:0] ovVal = 16'h0000;

  function automatic logic [15:0] memWord(input logic [15:0] a, input int mode, input logic en,
                                          input logic [15:0] oa, input logic [15:0] ov);
    logic [15:0] w;
    if (en && a == oa) return ov;
    if (mode == 0) begin
      w = 16'h1000 + a;
    end else begin
      w = {a[7:0], a[15:8]} ^ 16'h6C93;
`ifdef HALT_DETECT_EN
      if (w[15:12] == 4'hF) w = w ^ 16'h1000;
`endif
    end
    return w;
  endfunction

  always_comb bus.memData = memWord(bus.memAddress, memMode, ovEn, ovAddr, ovVal);

  // Reference model: next address to fetch, word on offer to decode, and request-gap bookkeeping.
  logic [15:0] expPc, expInstr, expPcOut;
  logic        expValid, expHalted, startup, gap;
  int          missRun;
  logic        lastRead;
  logic [15:0] lastAddr;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic expRead(input logic s, input logic b);
    return !startup && !gap && !expHalted && (!expValid || !s) && !b;
  endfunction

  task automatic modelReset();
    expPc = 16'h0000; expInstr = 16'h0000; expPcOut = 16'h0000;
    expValid = 1'b0; expHalted = 1'b0; startup = 1'b1; gap = 1'b0; missRun = 0;
  endtask

  task automatic modelEdge(input logic s, input logic r, input logic b, input logic [15:0] t,
                           input logic rdExp);
    logic [15:0] w;
    startup = 1'b0;
    gap = 1'b0;
    if (b && !expHalted) begin
      expPc = t; expValid = 1'b0; missRun = 0;
    end else if (rdExp && r) begin
      w = memWord(expPc, memMode, ovEn, ovAddr, ovVal);
      expInstr = w; expPcOut = expPc; expValid = 1'b1; expPc = expPc + 16'h0001; missRun = 0;
`ifdef HALT_DETECT_EN
      if (w[15:12] == 4'hF) expHalted = 1'b1;
`endif
    end else begin
      if (rdExp) begin
        missRun++;
        if (missRun == WAIT_LIMIT) begin
          gap = 1'b1;
          missRun = 0;
        end
      end
      if (expValid && !s) expValid = 1'b0;
    end
  endtask

  task automatic checkAll(input logic rdExp);
    chk("memRead", 16'(bus.memRead), 16'(rdExp));
    chk("memAddress", bus.memAddress, expPc);
    chk("valid", 16'(bus.valid), 16'(expValid));
    chk("instruction", bus.instruction, expInstr);
    chk("pcOut", bus.pcOut, expPcOut);
    chk("opcode", 16'(bus.opcode), 16'(expInstr[15:12]));
    chk("rs", 16'(bus.rs), 16'(expInstr[11:9]));
    chk("rt", 16'(bus.rt), 16'(expInstr[8:6]));
    chk("rd", 16'(bus.rd), 16'(expInstr[5:3]));
    chk("funct", 16'(bus.funct), 16'(expInstr[2:0]));
    chk("signalToExtend", 16'(bus.signalToExtend), 16'(expInstr[5:0]));
    chk("halted", 16'(bus.halted), 16'(expHalted));
  endtask

  // One clock: drive at negedge, check before the rising edge, advance the model on it.
  task automatic step(input logic s, input logic r, input logic b, input logic [15:0] t);
    logic rdExp;
    @(negedge clock);
    bus.stall = s; bus.memReady = r; bus.branchTaken = b; bus.branchTarget = t;
    #1;
    rdExp = expRead(s, b);
    lastRead = bus.memRead;
    lastAddr = bus.memAddress;
    checkAll(rdExp);
    @(posedge clock);
    modelEdge(s, r, b, t, rdExp);
  endtask

  task automatic doReset();
    @(negedge clock);
    reset = 1'b1;
    bus.stall = 1'b0; bus.memReady = 1'b0; bus.branchTaken = 1'b0; bus.branchTarget = 16'h0000;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", 16'(bus.valid), 16'h0000);
    chk("rst_instruction", bus.instruction, 16'h0000);
    chk("rst_pcOut", bus.pcOut, 16'h0000);
    chk("rst_memRead", 16'(bus.memRead), 16'h0000);
    chk("rst_memAddress", bus.memAddress, 16'h0000);
    chk("rst_opcode", 16'(bus.opcode), 16'h0000);
    chk("rst_signalToExtend", 16'(bus.signalToExtend), 16'h0000);
    chk("rst_halted", 16'(bus.halted), 16'h0000);
    reset = 1'b0;
    modelReset();
  endtask

  initial begin
    bus.stall = 1'b0; bus.memReady = 1'b0; bus.branchTaken = 1'b0; bus.branchTarget = 16'h0000;
    modelReset();
    doReset();

    // Streaming: first word appears two cycles after reset release, then one per cycle.
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    #1 chk("stream_first_valid", 16'(bus.valid), 16'h0000);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stream_valid", 16'(bus.valid), 16'h0001);
      chk("stream_pcOut", bus.pcOut, 16'(i));
      chk("stream_instruction", bus.instruction, 16'h1000 + 16'(i));
      step(1'b0, 1'b1, 1'b0, 16'h0000);
    end

    // Stall holds the 3A5C word at address 5; release brings address 6 with no gap.
    ovEn = 1'b1; ovAddr = 16'h0005; ovVal = 16'h3A5C;
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    #1 chk("stall_loaded", bus.instruction, 16'h3A5C);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 16'h0000);
      chk("stall_memRead", 16'(lastRead), 16'h0000);
      #1 chk("stall_hold", bus.instruction, 16'h3A5C);
    end
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    #1;
    chk("stall_next_pcOut", bus.pcOut, 16'h0006);
    chk("stall_next_instr", bus.instruction, 16'h1006);
    ovEn = 1'b0;

    // Redirect with memReady in the same cycle: data dropped, next fetch from target.
    step(1'b0, 1'b1, 1'b1, 16'h0040);
    #1;
    chk("branch_valid", 16'(bus.valid), 16'h0000);
    chk("branch_addr", bus.memAddress, 16'h0040);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    #1;
    chk("branch_pcOut", bus.pcOut, 16'h0040);
    chk("branch_instr", bus.instruction, 16'h1040);

    // Unanswered requests: 8 high, 1 low, high again at the same address.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0, 16'h0000);
      chk("retry_memRead", 16'(lastRead), (i == 8) ? 16'h0000 : 16'h0001);
      chk("retry_addr", lastAddr, 16'h0041);
    end
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    #1;
    chk("retry_pcOut", bus.pcOut, 16'h0041);
    chk("retry_instr", bus.instruction, 16'h1041);

    // PC wrap at the top of the address space.
    step(1'b0, 1'b0, 1'b1, 16'hFFFF);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    #1;
    chk("wrap_pcOut", bus.pcOut, 16'hFFFF);
    chk("wrap_instr", bus.instruction, 16'h0FFF);
    chk("wrap_addr", bus.memAddress, 16'h0000);

    // Opcode F word.
    ovEn = 1'b1; ovAddr = 16'h0000; ovVal = 16'hF000;
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    #1;
    chk("opF_valid", 16'(bus.valid), 16'h0001);
    chk("opF_opcode", 16'(bus.opcode), 16'h000F);
`ifdef HALT_DETECT_EN
    chk("halt_flag", 16'(bus.halted), 16'h0001);
    step(1'b0, 1'b1, 1'b1, 16'h0040);
    chk("halt_memRead", 16'(lastRead), 16'h0000);
    #1 chk("halt_branch_ignored", bus.memAddress, 16'h0001);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    ovEn = 1'b0;
    doReset();
`else
    chk("opF_not_halted", 16'(bus.halted), 16'h0000);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    chk("opF_continues", 16'(lastRead), 16'h0001);
    #1 chk("opF_next_pcOut", bus.pcOut, 16'h0001);
    ovEn = 1'b0;
`endif

    // Random stall / ready / redirect traffic against the model.
    memMode = 1;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 4,
           16'($urandom));
    end

    // Reset mid-stream restarts at RESET_PC.
    doReset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- IF stage of the 16-bit processor; the producer side of the decode-stage interface.
- Fetches 16-bit instruction words from instruction memory over a ready-based read handshake.
- Holds PC and the IF/ID output register; splits the held word into opcode/rs/rt/rd/funct/imm6 fields for the decode stage.
- Supports downstream stall, branch redirect/flush, and bounded-wait request retry.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
PC_STEP, 1, PC increment per fetched word (word addressed)
WAIT_LIMIT, 8, consecutive unanswered memRead cycles before a retry (range 1..255)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  decode stage cannot accept; output register holds
branchTaken  input  1  redirect PC this cycle
branchTarget  input  16  redirect address
memReady  input  1  memData valid for current memAddress
memData  input  16  instruction word from memory
memRead  output  1  read request
memAddress  output  16  word address, equals pc
valid  output  1  instruction register holds a live instruction
instruction  output  16  held instruction word
pcOut  output  16  address of held instruction
opcode  output  4  instruction[15:12]
rs  output  3  instruction[11:9]
rt  output  3  instruction[8:6]
rd  output  3  instruction[5:3]
funct  output  3  instruction[2:0]
signalToExtend  output  6  instruction[5:0]
halted  output  1  fetch halted (feature only; constant 0 otherwise)

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high, with ports named clock and reset.
- Reset (highest priority): state=IDLE, pc=RESET_PC, valid=0, instruction=0, pcOut=0, waitCount=0, halted=0. memRead=0 while in IDLE.
- States: IDLE, FETCH, RETRY (HALT with feature).
  - IDLE -> FETCH unconditionally after 1 cycle.
- accept = !valid || !stall.
- memRead = (state==FETCH) && accept && !branchTaken. Combinational.
- memAddress = pc always.
- Memory treats each memRead cycle independently; deasserting memRead cancels the request.
- FETCH, memRead && memReady:
  - instruction<=memData, pcOut<=pc, valid<=1.
  - pc<=pc+PC_STEP, modulo 2^16 (16'hFFFF -> 16'h0000).
  - waitCount<=0.
  - Latency 1 cycle from memReady to valid.
- FETCH, memRead && !memReady:
  - waitCount++.
  - When waitCount reaches WAIT_LIMIT-1 on this cycle: go RETRY, waitCount<=0.
- RETRY: memRead=0 for exactly 1 cycle, then FETCH with the same pc.
- Consumption: valid && !stall at an edge with no new word loaded -> valid<=0.
- Stall with valid=1: instruction, pcOut and valid hold; memRead=0; waitCount holds.
- branchTaken (priority over stall, memReady, RETRY; below reset):
  - pc<=branchTarget, valid<=0, waitCount<=0, state<=FETCH.
  - memReady in the same cycle is ignored.
  - First fetch from branchTarget is issued the next cycle.
- Field outputs are combinational slices of the instruction register. They are 0 after reset.
- No instruction is lost or duplicated under any stall pattern.

Optional Feature:
- Macro: HALT_DETECT_EN.
- Defined:
  - A word with opcode 4'hF loaded into the instruction register moves the FSM to HALT; halted<=1 the same edge.
  - That word is still presented with valid=1 and consumed normally.
  - In HALT: memRead=0, pc frozen, branchTaken ignored.
  - Exit from HALT only by reset.
- Undefined: opcode 4'hF is an ordinary word; halted is constant 0; no HALT state.

Test Plan:
- Reset, then memReady=1 every cycle, memData=16'h1000+addr, stall=0 -> valid rises 2 cycles after reset deasserts; pcOut 0,1,2,3 on consecutive cycles; instruction 16'h1000,16'h1001,...
- Fetch 16'h3A5C with stall=1 held 3 cycles -> instruction stays 16'h3A5C, memRead=0 during stall; after release, next word at pcOut+1 follows with no gap or duplicate.
- branchTaken=1, branchTarget=16'h0040 in the same cycle as memReady -> valid=0 next cycle; memData discarded; next memAddress=16'h0040.
- memReady held 0 with WAIT_LIMIT=8 -> memRead high 8 cycles, low 1 cycle (RETRY), high again at the same address; memReady=1 then loads the word.
- pc=16'hFFFF fetch -> pcOut=16'hFFFF, next memAddress=16'h0000.
- With HALT_DETECT_EN, fetch 16'hF000 -> valid=1 with opcode=4'hF, halted=1, memRead stays 0; branchTaken has no effect; reset clears halted and restarts at RESET_PC.
